hostcpu_bram_bridge: RTL

//  Host-CPU side bridge directly upstream of the dual-port OSD boot ROM/BRAM (32-bit words, byte enables, 1-cycle read latency).

---
 rtl/hostcpu_bram_pkg.sv | 13 +
 rtl/hostcpu_prefetch_buf.sv | 59 +++++
 rtl/hostcpu_bram_bridge.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hostcpu_bram_pkg.sv
// Shared definitions for the host-CPU to BRAM bridge.
// The BRAM returns read data one cycle after the address is presented.
package hostcpu_bram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } state_t;

  localparam int BRAM_RD_LATENCY = 1;

endpackage

// File: rtl/hostcpu_prefetch_buf.sv
// One-word sequential prefetch on BRAM port 2, with hit compare and write invalidate.
// A fill lands one cycle after issue; a fill is dropped if the target word is written meanwhile.
module hostcpu_prefetch_buf
  import hostcpu_bram_pkg::*;
#(
  parameter int WA = 14
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [WA-1:0] i_lookup_addr,
  input  logic          i_rd_issue,
  input  logic          i_wr_inval,
  input  logic [31:0]   i_q2,
  output logic          o_hit,
  output logic [31:0]   o_pf_data,
  output logic [WA-1:0] o_ram_addr2
);

  logic [WA-1:0] r_pf_addr;
  logic [31:0]   r_pf_data;
  logic          r_pf_valid;
  logic          r_pf_pending;
  logic [WA-1:0] r_pend_addr;
  logic [WA-1:0] w_next_addr;
  logic          w_pend_cancel;

  assign w_next_addr   = i_lookup_addr + WA'(1);
  assign w_pend_cancel = i_wr_inval && (r_pend_addr == i_lookup_addr);

  assign o_hit       = r_pf_valid && (r_pf_addr == i_lookup_addr);
  assign o_pf_data   = r_pf_data;
  // Port 2 must see the address on the accepting edge so q2 is ready one edge later.
  assign o_ram_addr2 = i_rd_issue ? w_next_addr : r_pend_addr;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_pf_addr    <= '0;
      r_pf_data    <= '0;
      r_pf_valid   <= 1'b0;
      r_pf_pending <= 1'b0;
      r_pend_addr  <= '0;
    end else begin
      if (i_wr_inval && r_pf_valid && (r_pf_addr == i_lookup_addr))
        r_pf_valid <= 1'b0;
      if (i_rd_issue) begin
        r_pf_pending <= 1'b1;
        r_pend_addr  <= w_next_addr;
      end else if (r_pf_pending) begin
        r_pf_pending <= 1'b0;
        if (!w_pend_cancel) begin
          r_pf_data  <= i_q2;
          r_pf_addr  <= r_pend_addr;
          r_pf_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/hostcpu_bram_bridge.sv
// CPU req/ack to BRAM bridge: writes and prefetch hits ack one cycle after acceptance, misses two.
// One access in flight; cpu_req is only sampled in IDLE, so the CPU is stalled until ack.
module hostcpu_bram_bridge
  import hostcpu_bram_pkg::*;
#(
  parameter int WORD_ADDR_WIDTH = 14,
  parameter int PREFETCH        = 1,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_cpu_req,
  input  logic                       i_cpu_wr,
  input  logic [WORD_ADDR_WIDTH+1:0] i_cpu_addr,
  input  logic [3:0]                 i_cpu_bytesel,
  input  logic [31:0]                i_cpu_wdata,
  output logic [31:0]                o_cpu_rdata,
  output logic                       o_cpu_ack,
  output logic [WORD_ADDR_WIDTH-1:0] o_ram_addr,
  output logic [31:0]                o_ram_d,
  output logic                       o_ram_we,
  output logic [3:0]                 o_ram_bytesel,
  input  logic [31:0]                i_ram_q,
  output logic [WORD_ADDR_WIDTH-1:0] o_ram_addr2,
  input  logic [31:0]                i_ram_q2,
  output logic                       o_ram_we2,
  output logic [31:0]                o_ram_d2,
  output logic [3:0]                 o_ram_bytesel2,
  output logic [CNT_WIDTH-1:0]       o_rd_count,
  output logic [CNT_WIDTH-1:0]       o_hit_count
);

  localparam int WA = WORD_ADDR_WIDTH;

  state_t         r_state, w_state_nxt;
  logic [WA-1:0]  w_word;
  logic           w_accept, w_wr_issue, w_rd_issue, w_rd_hit, w_wr_inval;
  logic           w_hit, w_ack, w_rd_done;
  logic [31:0]    w_pf_data;
  logic [WA-1:0]  r_ram_addr;
  logic [31:0]    r_ram_d, r_cpu_rdata;
  logic           r_ram_we;
  logic [3:0]     r_ram_bytesel;
  logic [CNT_WIDTH-1:0] r_rd_count, r_hit_count;
  logic           w_unused;

  assign w_word     = i_cpu_addr[WA+1:2];
  assign w_accept   = (r_state == ST_IDLE) && i_cpu_req && i_reset_n;
  assign w_wr_issue = w_accept && i_cpu_wr;
  assign w_rd_issue = w_accept && !i_cpu_wr;
  assign w_rd_hit   = w_rd_issue && w_hit;
  assign w_wr_inval = w_wr_issue && (i_cpu_bytesel != 4'b0000);
  assign w_rd_done  = w_rd_hit || (r_state == ST_RD_WAIT);
  assign w_unused   = &{1'b0, i_cpu_addr[1:0], i_ram_q2};

  generate
    if (PREFETCH != 0) begin : g_pf
      hostcpu_prefetch_buf #(.WA(WA)) u_pf (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_lookup_addr (w_word),
        .i_rd_issue    (w_rd_issue),
        .i_wr_inval    (w_wr_inval),
        .i_q2          (i_ram_q2),
        .o_hit         (w_hit),
        .o_pf_data     (w_pf_data),
        .o_ram_addr2   (o_ram_addr2)
      );
    end else begin : g_no_pf
      assign w_hit       = 1'b0;
      assign w_pf_data   = '0;
      assign o_ram_addr2 = '0;
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) r_state <= ST_IDLE;
    else            r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_wr_issue || w_rd_hit) w_state_nxt = ST_ACK;
        else if (w_rd_issue)        w_state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: w_state_nxt = ST_ACK;
      ST_ACK:     w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_ack = 1'b0;
    if (r_state == ST_ACK) w_ack = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_ram_addr    <= '0;
      r_ram_d       <= '0;
      r_ram_we      <= 1'b0;
      r_ram_bytesel <= '0;
      r_cpu_rdata   <= '0;
      r_rd_count    <= '0;
      r_hit_count   <= '0;
    end else begin
      r_ram_we      <= w_wr_issue;
      r_ram_d       <= w_wr_issue ? i_cpu_wdata : '0;
      r_ram_bytesel <= w_wr_issue ? i_cpu_bytesel : '0;
      if (w_accept) r_ram_addr <= w_word;
      if (w_rd_hit)                      r_cpu_rdata <= w_pf_data;
      else if (r_state == ST_RD_WAIT)    r_cpu_rdata <= i_ram_q;
      if (w_rd_done && (r_rd_count != '1))
        r_rd_count <= r_rd_count + CNT_WIDTH'(1);
      if (w_rd_hit && (r_hit_count != '1))
        r_hit_count <= r_hit_count + CNT_WIDTH'(1);
    end
  end

  // A read miss drives the word address combinationally so BRAM data is ready in RD_WAIT.
  assign o_ram_addr     = w_rd_issue ? w_word : r_ram_addr;
  assign o_ram_d        = r_ram_d;
  assign o_ram_we       = r_ram_we;
  assign o_ram_bytesel  = r_ram_bytesel;
  assign o_cpu_rdata    = r_cpu_rdata;
  assign o_cpu_ack      = w_ack;
  assign o_ram_we2      = 1'b0;
  assign o_ram_d2       = '0;
  assign o_ram_bytesel2 = '0;
  assign o_rd_count     = r_rd_count;
  assign o_hit_count    = r_hit_count;

endmodule
